fcvt_issue: RTL and testbench

- Issue/sequencing stage directly upstream of the combinational int-to-float (itof) and float-to-int (ftoi) converters.
- Accepts conversion requests from the core with a valid/ready handshake and buffers them in a small FIFO.
- Drives the selected converter's operand stably for LATENCY cycles, registers the result, and returns it with its destination tag under a valid/ready handshake.

---
 rtl/fcvt_pkg.sv | 14 +
 rtl/fcvt_fifo.sv | 54 +++++
 rtl/fcvt_issue.sv | 111 +++++++++++
 tb/tb_fcvt_issue.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcvt_pkg.sv
// Shared definitions for the conversion issue stage: opcodes, FSM encoding
// and the default destination-tag width.
package fcvt_pkg;

  localparam logic OP_ITOF = 1'b0;
  localparam logic OP_FTOI = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int TAG_W_DEF = 5;

endpackage

// File: rtl/fcvt_fifo.sv
// Small synchronous request FIFO; head data is presented combinationally
// from the read pointer so a pop captures it on the same edge.
module fcvt_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is ignored even if a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fcvt_issue.sv
// Issue stage for the external combinational itof/ftoi converters: buffers
// requests, holds the operand for LATENCY cycles and returns tagged results.
module fcvt_issue
  import fcvt_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_src,
  output logic             cvt_op,
  output logic [31:0]      cvt_src,
  input  logic [31:0]      itof_result,
  input  logic [31:0]      ftoi_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic             busy
);

  localparam int FW = 1 + TAG_W + 32;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready depends only on registered FIFO state; resp_valid, resp_tag and
  // resp_data stay stable until the consumer accepts.
  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [TAG_W-1:0] tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [FW-1:0]    head;

  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;

  fcvt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req_op, req_tag, req_src}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pops happen from IDLE, or from RESP on the accepting edge for back-to-back issue.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE: pop = !fifo_empty;
      ST_RESP: pop = resp_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      tag        <= '0;
      cvt_op     <= 1'b0;
      cvt_src    <= '0;
      resp_valid <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
    end else begin
      if (pop) begin
        {cvt_op, tag, cvt_src} <= head;
        cnt                    <= 4'(LATENCY - 1);
      end
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            resp_data  <= (cvt_op == OP_FTOI) ? ftoi_result : itof_result;
            resp_tag   <= tag;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= fifo_empty ? ST_IDLE : ST_EXEC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_fcvt_issue.sv
// Directed bench for fcvt_issue: one instance at LATENCY=1 and one at
// LATENCY=4, both driven by behavioural itof/ftoi converter models.
module tb_fcvt_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [4:0]  req_tag = '0;
  logic [31:0] req_src = '0;
  logic        cvt_op;
  logic [31:0] cvt_src, itof_result, ftoi_result;
  logic        resp_valid, resp_ready = 1'b0, busy;
  logic [4:0]  resp_tag;
  logic [31:0] resp_data;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_op = 1'b0;
  logic [4:0]  b_req_tag = '0;
  logic [31:0] b_req_src = '0;
  logic        b_cvt_op;
  logic [31:0] b_cvt_src, b_itof_result, b_ftoi_result;
  logic        b_resp_valid, b_resp_ready = 1'b0, b_busy;
  logic [4:0]  b_resp_tag;
  logic [31:0] b_resp_data;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] m_itof(input logic [31:0] x);
    logic [31:0] a, m, rem, half;
    logic [7:0]  e;
    int p, sh;
    if (x == 32'd0) return 32'd0;
    a = x[31] ? (~x + 32'd1) : x;
    p = 31;
    while (!a[p]) p--;
    e = 8'(127 + p);
    if (p <= 23) begin
      m = a << (23 - p);
    end else begin
      sh   = p - 23;
      m    = a >> sh;
      rem  = a & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 32'd1;
      if (m[24]) begin
        m = m >> 1;
        e = e + 8'd1;
      end
    end
    return {x[31], e, m[22:0]};
  endfunction

  function automatic logic [31:0] m_ftoi(input logic [31:0] f);
    logic [7:0]  e;
    logic [31:0] m, mag;
    int sh;
    e = f[30:23];
    m = {8'd0, 1'b1, f[22:0]};
    if (e < 8'd127) return 32'd0;
    if (e >= 8'd158) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    sh  = int'(e) - 127;
    mag = (sh >= 23) ? (m << (sh - 23)) : (m >> (23 - sh));
    return f[31] ? (~mag + 32'd1) : mag;
  endfunction

  assign itof_result   = m_itof(cvt_src);
  assign ftoi_result   = m_ftoi(cvt_src);
  assign b_itof_result = m_itof(b_cvt_src);
  assign b_ftoi_result = m_ftoi(b_cvt_src);

  fcvt_issue #(.LATENCY(1), .TAG_W(5), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_tag(req_tag), .req_src(req_src),
    .cvt_op(cvt_op), .cvt_src(cvt_src),
    .itof_result(itof_result), .ftoi_result(ftoi_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_tag(resp_tag), .resp_data(resp_data), .busy(busy)
  );

  fcvt_issue #(.LATENCY(4), .TAG_W(5), .FIFO_DEPTH(2)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_tag(b_req_tag), .req_src(b_req_src),
    .cvt_op(b_cvt_op), .cvt_src(b_cvt_src),
    .itof_result(b_itof_result), .ftoi_result(b_ftoi_result),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_tag(b_resp_tag), .resp_data(b_resp_data), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the edge that accepts it.
  task automatic push_a(input logic op, input logic [4:0] tag, input logic [31:0] src);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_tag = tag; req_src = src;
    while (!req_ready && n < 50) begin tick(); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_a_timeout: req_ready=%b required 1 (tag %0d)", req_ready, tag);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic push_b(input logic op, input logic [4:0] tag, input logic [31:0] src);
    int n = 0;
    b_req_valid = 1'b1; b_req_op = op; b_req_tag = tag; b_req_src = src;
    while (!b_req_ready && n < 50) begin tick(); n++; end
    checks++;
    if (b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_b_timeout: req_ready=%b required 1 (tag %0d)", b_req_ready, tag);
    end
    tick();
    b_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b need 0", resp_valid); end
    checks++; if (cvt_op !== 1'b0) begin errors++; $display("FAIL rst_cvt_op: got %b need 0", cvt_op); end
    checks++; if (cvt_src !== 32'd0) begin errors++; $display("FAIL rst_cvt_src: got %h need 0", cvt_src); end
    checks++; if (resp_tag !== 5'd0) begin errors++; $display("FAIL rst_resp_tag: got %h need 0", resp_tag); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL rst_resp_data: got %h need 0", resp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b need 1", req_ready); end
    checks++; if (b_resp_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_b_idle: valid=%b busy=%b need 0 0", b_resp_valid, b_busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    resp_ready = 1'b1;
    push_a(1'b0, 5'd3, 32'h0000_0001);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_c1: got %b need 0", resp_valid); end
    tick();
    checks++; if (resp_valid !== 1'b0 || cvt_src !== 32'h1) begin errors++; $display("FAIL basic_c1: valid=%b src=%h need 0 00000001", resp_valid, cvt_src); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_c2: got %b need 1", resp_valid); end
    checks++; if (resp_data !== 32'h3F80_0000) begin errors++; $display("FAIL basic_data: got %h need 3f800000", resp_data); end
    checks++; if (resp_tag !== 5'd3) begin errors++; $display("FAIL basic_tag: got %0d need 3", resp_tag); end
    tick();
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_drain: valid=%b busy=%b need 0 0", resp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] e;
    logic        prev_op;
    int          nresp = 0;
    int          nchg = 0;
    resp_ready = 1'b1;
    exp_q.push_back({5'd1, 32'hC000_0000});
    exp_q.push_back({5'd2, 32'h0000_0003});
    prev_op = cvt_op;
    push_a(1'b0, 5'd1, 32'hFFFF_FFFE);
    push_a(1'b1, 5'd2, 32'h4040_0000);
    for (int i = 0; i < 20; i++) begin
      if (cvt_op !== prev_op) begin
        nchg++;
        checks++;
        if (nresp != 1 || cvt_op !== 1'b1) begin
          errors++; $display("FAIL b2b_op_switch: op=%b after %0d responses, need op 1 after 1", cvt_op, nresp);
        end
        prev_op = cvt_op;
      end
      if (resp_valid) begin
        nresp++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: tag=%0d data=%h, none expected", resp_tag, resp_data);
        end else begin
          e = exp_q.pop_front();
          if ({resp_tag, resp_data} !== e) begin
            errors++; $display("FAIL b2b_resp: got tag %0d data %h need tag %0d data %h", resp_tag, resp_data, e[36:32], e[31:0]);
          end
        end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0 || nchg != 1) begin errors++; $display("FAIL b2b_count: %0d missing, %0d op switches, need 0 1", exp_q.size(), nchg); end
    exp_q.delete();
  endtask

  task automatic test_stall_and_full();
    logic [36:0] e;
    logic [31:0] held_d;
    logic [4:0]  held_t;
    int          nresp = 0;
    resp_ready = 1'b0;
    push_a(1'b0, 5'd4, 32'd5);
    push_a(1'b1, 5'd5, 32'h4120_0000);
    push_a(1'b0, 5'd6, 32'd100);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready: got %b need 0", req_ready); end
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd4 || resp_data !== 32'h40A0_0000) begin
      errors++; $display("FAIL stall_head: valid=%b tag=%0d data=%h need 1 4 40a00000", resp_valid, resp_tag, resp_data);
    end
    held_d = 32'h40A0_0000; held_t = 5'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== held_d || resp_tag !== held_t || req_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold: valid=%b tag=%0d data=%h ready=%b need 1 4 40a00000 0", resp_valid, resp_tag, resp_data, req_ready);
      end
    end
    // Offer a fourth request while full, on the same edge the head is accepted.
    req_valid = 1'b1; req_op = 1'b1; req_tag = 5'd7; req_src = 32'hC0A0_0000;
    resp_ready = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL full_pop_edge: ready=%b valid=%b need 1 0", req_ready, resp_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_next_push: ready=%b need 0", req_ready); end
    exp_q.push_back({5'd5, 32'h0000_000A});
    exp_q.push_back({5'd6, 32'h42C8_0000});
    exp_q.push_back({5'd7, 32'hFFFF_FFFB});
    for (int i = 0; i < 30; i++) begin
      if (resp_valid) begin
        nresp++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL full_extra: tag=%0d data=%h, none expected", resp_tag, resp_data);
        end else begin
          e = exp_q.pop_front();
          if ({resp_tag, resp_data} !== e) begin
            errors++; $display("FAIL full_resp: got tag %0d data %h need tag %0d data %h", resp_tag, resp_data, e[36:32], e[31:0]);
          end
        end
      end
      tick();
    end
    checks++; if (nresp != 3 || busy !== 1'b0) begin errors++; $display("FAIL full_drain: %0d responses busy=%b need 3 0", nresp, busy); end
    exp_q.delete();
  endtask

  task automatic test_latency4();
    b_resp_ready = 1'b1;
    push_b(1'b0, 5'd9, 32'd7);
    checks++; if (b_resp_valid !== 1'b0) begin errors++; $display("FAIL l4_c0: valid=%b need 0", b_resp_valid); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (b_resp_valid !== 1'b0 || b_cvt_src !== 32'd7 || b_cvt_op !== 1'b0) begin
        errors++; $display("FAIL l4_hold_c%0d: valid=%b src=%h op=%b need 0 00000007 0", k, b_resp_valid, b_cvt_src, b_cvt_op);
      end
    end
    tick();
    checks++; if (b_resp_valid !== 1'b1 || b_resp_data !== 32'h40E0_0000 || b_resp_tag !== 5'd9) begin
      errors++; $display("FAIL l4_resp_c5: valid=%b data=%h tag=%0d need 1 40e00000 9", b_resp_valid, b_resp_data, b_resp_tag);
    end
    tick();
    checks++; if (b_resp_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL l4_drain: valid=%b busy=%b need 0 0", b_resp_valid, b_busy); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    b_resp_ready = 1'b1;
    push_b(1'b0, 5'd10, 32'd1);
    push_b(1'b0, 5'd11, 32'd2);
    push_b(1'b1, 5'd12, 32'h4040_0000);
    checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b0) begin
      errors++; $display("FAIL rmid_pre: valid=%b ready=%b need 0 0 (EXEC, two queued)", b_resp_valid, b_req_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b_resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b need 0", b_resp_valid); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b need 0", b_busy); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b need 1", b_req_ready); end
    for (int i = 0; i < 30; i++) begin
      if (b_resp_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rmid_stale: %0d stale response cycles, need 0", stale); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall_and_full();
    test_latency4();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
